// File: rtl/reg_bank_dual_rd.sv
// Register bank with a debounced pushbutton write port and two registered read ports.
// Each read port is write-first: it returns dat_wr when reading the address being written.
module reg_bank_dual_rd #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 3,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_rd1,
  input  logic [ADDR_W-1:0] addr_rd2,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [DATA_W-1:0] dat_wr,
  input  logic              wr_btn,
  output logic [DATA_W-1:0] dat_rd1,
  output logic [DATA_W-1:0] dat_rd2,
  output logic              wr_done,
  output logic              busy
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, WRITE, WAIT_REL} state_t;

  state_t                             state, state_nxt;
  logic [CNT_W-1:0]                   cnt, cnt_nxt;
  logic                               s1, s2;
  logic                               wr_en;
  logic [DEPTH-1:0][DATA_W-1:0]       mem;
  logic [NUM_RD-1:0][ADDR_W-1:0]      addr_rd;
  logic [NUM_RD-1:0][DATA_W-1:0]      dat_rd;

  assign addr_rd = {addr_rd2, addr_rd1};
  assign dat_rd1 = dat_rd[0];
  assign dat_rd2 = dat_rd[1];
  assign wr_en   = (state == WRITE);
  assign wr_done = wr_en;
  assign busy    = (state != IDLE);

  // two-flop synchroniser; the FSM only ever looks at s2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= wr_btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (s2) begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
      SETTLE: begin
        if (!s2)                 state_nxt = IDLE;
        else if (cnt == CNT_MAX) state_nxt = WRITE;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      WRITE: begin
        state_nxt = WAIT_REL;
        cnt_nxt   = '0;
      end
      WAIT_REL: begin
        // any high sample restarts the release window
        if (s2)                  cnt_nxt   = '0;
        else if (cnt == CNT_MAX) state_nxt = IDLE;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else if (wr_en) begin
      mem[addr_wr] <= dat_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_rd <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++)
        dat_rd[p] <= (wr_en && addr_wr == addr_rd[p]) ? dat_wr : mem[addr_rd[p]];
    end
  end
endmodule

// File: tb/tb_reg_bank_dual_rd.sv
// Directed bench for reg_bank_dual_rd with DEBOUNCE_CYC=4, expected values worked out by hand.
module tb_reg_bank_dual_rd;
  localparam int DATA_W = 4, ADDR_W = 3, DEB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr_rd1, addr_rd2, addr_wr;
  logic [DATA_W-1:0] dat_wr;
  logic              wr_btn;
  logic [DATA_W-1:0] dat_rd1, dat_rd2;
  logic              wr_done, busy;

  int n_chk  = 0;
  int n_fail = 0;

  reg_bank_dual_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .rst(rst), .addr_rd1(addr_rd1), .addr_rd2(addr_rd2),
    .addr_wr(addr_wr), .dat_wr(dat_wr), .wr_btn(wr_btn),
    .dat_rd1(dat_rd1), .dat_rd2(dat_rd2), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one edge, then settle 1ns so outputs are stable and new inputs land mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold the button for 'hold' edges, recording wr_done pulses, then release and re-arm
  task automatic press(input int hold, output int ndone, output int first);
    ndone  = 0;
    first  = -1;
    wr_btn = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (wr_done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    wr_btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (wr_done) ndone++;
    end
  endtask

  task automatic rd1(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    addr_rd1 = a;
    tick();
    d = dat_rd1;
  endtask

  int               nd, fd;
  logic [DATA_W-1:0] d;

  initial begin
    rst = 1'b1; wr_btn = 1'b0; addr_rd1 = '0; addr_rd2 = '0; addr_wr = '0; dat_wr = '0;
    tick(); tick();
    chk("rst_rd1", dat_rd1, 0);
    chk("rst_rd2", dat_rd2, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // 1: reset contents on both ports, ports on different addresses
    for (int a = 0; a < 8; a++) begin
      addr_rd1 = ADDR_W'(a);
      addr_rd2 = ADDR_W'(7 - a);
      tick();
      chk("init_rd1", dat_rd1, a);
      chk("init_rd2", dat_rd2, 7 - a);
    end

    // 2: write latency; WRITE in the 7th edge-interval after the first high sample
    addr_wr = 3'd5; dat_wr = 4'hC; addr_rd1 = 3'd5; addr_rd2 = 3'd0;
    wr_btn = 1'b1;
    nd = 0; fd = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 1) chk("lat_busy_early", busy, 0);
      if (k == 2) chk("lat_busy", busy, 1);
      if (k == 6) chk("lat_rd_before", dat_rd1, 5);
      if (k == 7) chk("lat_rd_after", dat_rd1, 4'hC);
      if (wr_done) begin
        nd++;
        if (fd < 0) fd = k;
      end
    end
    chk("lat_ndone", nd, 1);
    chk("lat_when", fd, 6);
    wr_btn = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("lat_idle", busy, 0);

    // 3: short glitches never reach the debounce terminal count
    addr_wr = 3'd5; dat_wr = 4'h1; nd = 0;
    for (int p = 0; p < 3; p++) begin
      wr_btn = 1'b1;
      tick(); if (wr_done) nd++;
      tick(); if (wr_done) nd++;
      wr_btn = 1'b0;
      tick(); if (wr_done) nd++;
    end
    for (int k = 0; k < 10; k++) begin
      tick(); if (wr_done) nd++;
    end
    chk("glitch_ndone", nd, 0);
    chk("glitch_busy", busy, 0);
    rd1(3'd5, d);
    chk("glitch_mem", d, 4'hC);

    // 4: long hold gives one write; data change mid-hold is ignored
    addr_wr = 3'd2; dat_wr = 4'h9; nd = 0;
    wr_btn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(); if (wr_done) nd++;
    end
    dat_wr = 4'h6;
    for (int k = 0; k < 3; k++) begin
      tick(); if (wr_done) nd++;
    end
    wr_btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(); if (wr_done) nd++;
    end
    chk("hold_ndone", nd, 1);
    rd1(3'd2, d);
    chk("hold_mem", d, 4'h9);
    dat_wr = 4'hA;
    press(10, nd, fd);
    chk("second_ndone", nd, 1);
    rd1(3'd2, d);
    chk("second_mem", d, 4'hA);

    // 5: write-first bypass on both ports at the committing edge
    addr_rd1 = 3'd3; addr_rd2 = 3'd3; addr_wr = 3'd3; dat_wr = 4'hF;
    tick();
    chk("byp_pre1", dat_rd1, 3);
    chk("byp_pre2", dat_rd2, 3);
    wr_btn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 6) begin
        chk("byp_wr_done", wr_done, 1);
        chk("byp_mid1", dat_rd1, 3);
        chk("byp_mid2", dat_rd2, 3);
      end
      if (k == 7) begin
        chk("byp_rd1", dat_rd1, 4'hF);
        chk("byp_rd2", dat_rd2, 4'hF);
      end
    end
    wr_btn = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    // 6: reset during WRITE aborts the write and restores the bank
    addr_wr = 3'd4; dat_wr = 4'hE; addr_rd1 = 3'd0; addr_rd2 = 3'd0;
    wr_btn = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    chk("abort_in_write", wr_done, 1);
    rst = 1'b1;
    tick();
    chk("abort_done", wr_done, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0; wr_btn = 1'b0;
    rd1(3'd4, d);
    chk("abort_mem4", d, 4);
    rd1(3'd3, d);
    chk("abort_mem3", d, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
